// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 display path.
package chip8_pkg;

    localparam int FB_WIDTH_DEF  = 64;
    localparam int FB_HEIGHT_DEF = 32;
    localparam int VRAM_ADDR_W   = 11;
    localparam int PIXEL_W       = 32;
    localparam int X_W           = 6;
    localparam int Y_W           = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic [PIXEL_W-1:0] data;
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic               sof;
        logic               eol;
    } pix_beat_t;

endpackage

// File: rtl/chip8_scanout_if.sv
// Pixel stream handshake: valid/ready plus one pixel beat.
interface chip8_scanout_if;
    import chip8_pkg::*;

    logic      valid;
    logic      ready;
    pix_beat_t beat;

    modport master (output valid, output beat, input ready);
    modport slave  (input valid, input beat, output ready);

endinterface

// File: rtl/chip8_pix_fifo.sv
// Two-entry pixel FIFO; the head register drives the stream directly so
// outputs are registered and hold stable while the sink stalls.
module chip8_pix_fifo
    import chip8_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  pix_beat_t              i_beat,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [1:0]             o_count,
    chip8_scanout_if.master        o_pix
);

    pix_beat_t r_head;
    pix_beat_t r_tail;
    logic      r_head_vld;
    logic      r_tail_vld;
    logic      w_pop;

    assign w_pop = r_head_vld && o_pix.ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_head_vld <= 1'b0;
            r_tail_vld <= 1'b0;
        end else if (w_pop) begin
            if (r_tail_vld) begin
                r_head     <= r_tail;
                r_tail_vld <= i_push;
                if (i_push) r_tail <= i_beat;
            end else if (i_push) begin
                r_head <= i_beat;
            end else begin
                r_head_vld <= 1'b0;
            end
        end else if (i_push) begin
            if (!r_head_vld) begin
                r_head     <= i_beat;
                r_head_vld <= 1'b1;
            end else begin
                r_tail     <= i_beat;
                r_tail_vld <= 1'b1;
            end
        end
    end

    assign o_pix.valid = r_head_vld;
    assign o_pix.beat  = r_head;
    assign o_full      = r_tail_vld;
    assign o_empty     = !r_head_vld;
    assign o_count     = {1'b0, r_head_vld} + {1'b0, r_tail_vld};

endmodule

// File: rtl/chip8_scanout.sv
// Frame scanner: walks VRAM in raster order and streams colour-mapped pixels
// with sof/eol markers, never holding more than two pixels in the pipeline.
module chip8_scanout
    import chip8_pkg::*;
#(
    parameter int                 FB_WIDTH  = FB_WIDTH_DEF,
    parameter int                 FB_HEIGHT = FB_HEIGHT_DEF,
    parameter logic [PIXEL_W-1:0] ON_COLOR  = 32'hFFFF_FFFF,
    parameter logic [PIXEL_W-1:0] OFF_COLOR = 32'h0000_0000
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   frame_req_in,
    output logic                   busy_out,
    output logic                   frame_done_out,
    output logic [7:0]             overrun_count_out,
    output logic                   vram_rd_en_out,
    output logic [VRAM_ADDR_W-1:0] vram_rd_addr_out,
    input  logic [PIXEL_W-1:0]     vram_rd_data_in,
    output logic                   pix_valid_out,
    input  logic                   pix_ready_in,
    output logic [PIXEL_W-1:0]     pix_data_out,
    output logic                   pix_sof_out,
    output logic                   pix_eol_out,
    output logic [X_W-1:0]         pix_x_out,
    output logic [Y_W-1:0]         pix_y_out
);

    localparam logic [VRAM_ADDR_W-1:0] LAST_ADDR = VRAM_ADDR_W'(FB_WIDTH*FB_HEIGHT-1);
    localparam logic [X_W-1:0]         LAST_X    = X_W'(FB_WIDTH-1);
    localparam logic [Y_W-1:0]         LAST_Y    = Y_W'(FB_HEIGHT-1);

    scan_state_t            r_state;
    logic [VRAM_ADDR_W-1:0] r_rd_addr;
    logic                   r_pend;
    logic [X_W-1:0]         r_x;
    logic [Y_W-1:0]         r_y;
    logic                   r_done;
    logic [7:0]             r_ovr;

    logic       w_pop, w_rd_en, w_start, w_drop, w_done;
    logic       w_full, w_empty;
    logic [1:0] w_count;
    logic [2:0] w_used;
    pix_beat_t  w_beat;

    chip8_scanout_if w_pix_if ();

    chip8_pix_fifo u_fifo (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_push  (r_pend),
        .i_beat  (w_beat),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_pix   (w_pix_if)
    );

    assign w_pix_if.ready = pix_ready_in;
    assign w_pop          = w_pix_if.valid && pix_ready_in;

    // A beat leaving this cycle frees its slot in time for a back-to-back read.
    assign w_used  = {1'b0, w_count} + {2'b0, r_pend} - {2'b0, w_pop};
    assign w_rd_en = (r_state == ST_SCAN) && (w_used < 3'd2);
    assign w_start = frame_req_in && (r_state == ST_IDLE) && !r_done;
    assign w_drop  = frame_req_in && !w_start;
    assign w_done  = (r_state == ST_DRAIN) && !r_pend && (w_empty || (w_pop && !w_full));

    assign w_beat.data = (|vram_rd_data_in) ? ON_COLOR : OFF_COLOR;
    assign w_beat.x    = r_x;
    assign w_beat.y    = r_y;
    assign w_beat.sof  = (r_x == '0) && (r_y == '0);
    assign w_beat.eol  = (r_x == LAST_X);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= ST_IDLE;
            r_rd_addr <= '0;
            r_pend    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_done    <= 1'b0;
            r_ovr     <= '0;
        end else begin
            r_done <= w_done;
            r_pend <= w_rd_en;
            if (w_drop && (r_ovr != 8'hFF)) r_ovr <= r_ovr + 8'd1;
            if (r_pend) begin
                if (r_x == LAST_X) begin
                    r_x <= '0;
                    r_y <= (r_y == LAST_Y) ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
            case (r_state)
                ST_IDLE: if (w_start) begin
                    r_state   <= ST_SCAN;
                    r_rd_addr <= '0;
                    r_x       <= '0;
                    r_y       <= '0;
                end
                ST_SCAN: if (w_rd_en) begin
                    if (r_rd_addr == LAST_ADDR) r_state <= ST_DRAIN;
                    else                        r_rd_addr <= r_rd_addr + 1'b1;
                end
                ST_DRAIN: if (w_done) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_out          = (r_state != ST_IDLE);
    assign frame_done_out    = r_done;
    assign overrun_count_out = r_ovr;
    assign vram_rd_en_out    = w_rd_en;
    assign vram_rd_addr_out  = r_rd_addr;
    assign pix_valid_out     = w_pix_if.valid;
    assign pix_data_out      = w_pix_if.beat.data;
    assign pix_sof_out       = w_pix_if.beat.sof;
    assign pix_eol_out       = w_pix_if.beat.eol;
    assign pix_x_out         = w_pix_if.beat.x;
    assign pix_y_out         = w_pix_if.beat.y;

endmodule

// File: tb/tb_chip8_scanout.sv
// Directed bench for chip8_scanout: VRAM model, pixel scoreboard, one line per frame.
module tb_chip8_scanout;
    import chip8_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_req = 1'b0;
    logic        pix_ready = 1'b0;
    logic        busy, done, rd_en, valid, sof, eol;
    logic [10:0] rd_addr;
    logic [31:0] rd_data = '0;
    logic [31:0] pdata;
    logic [5:0]  px;
    logic [4:0]  py;
    logic [7:0]  ovr;
    logic [31:0] vram [0:2047];

    int n_checks = 0, n_errors = 0;
    int ready_mode = 0;
    int beat_total = 0, frame_base = 0, rd_total = 0, rd_base = 0, done_total = 0;
    int cyc = 0, last_hs = 0, exp_ovr = 0, frame_no = 0;

    chip8_scanout_if mon_if ();

    always #5 clk = ~clk;

    chip8_scanout dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .frame_req_in      (frame_req),
        .busy_out          (busy),
        .frame_done_out    (done),
        .overrun_count_out (ovr),
        .vram_rd_en_out    (rd_en),
        .vram_rd_addr_out  (rd_addr),
        .vram_rd_data_in   (rd_data),
        .pix_valid_out     (valid),
        .pix_ready_in      (pix_ready),
        .pix_data_out      (pdata),
        .pix_sof_out       (sof),
        .pix_eol_out       (eol),
        .pix_x_out         (px),
        .pix_y_out         (py)
    );

    assign mon_if.valid = valid;
    assign mon_if.ready = pix_ready;
    assign mon_if.beat  = {pdata, px, py, sof, eol};

    always_ff @(posedge clk) if (rd_en) rd_data <= vram[rd_addr];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pix_beat_t exp_beat(input int k);
        pix_beat_t b;
        b.data = (vram[k] != 32'h0) ? 32'hFFFF_FFFF : 32'h0;
        b.x    = 6'(k % 64);
        b.y    = 5'(k / 64);
        b.sof  = (k == 0);
        b.eol  = ((k % 64) == 63);
        return b;
    endfunction

    // Sink ready: 0 = held low, 1 = held high, otherwise random 50%.
    initial forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       pix_ready = 1'b0;
            1:       pix_ready = 1'b1;
            default: pix_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard and protocol monitor, sampled on the falling edge.
    initial begin
        pix_beat_t cur, stall_beat;
        logic stalled;
        int k;
        stalled = 1'b0;
        stall_beat = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                cur = mon_if.beat;
                if (rd_en) rd_total++;
                if (stalled) check_eq("stall", 64'({mon_if.valid, cur}), 64'({1'b1, stall_beat}));
                if (mon_if.valid && mon_if.ready) begin
                    k = beat_total - frame_base;
                    if (k > 2047) check_eq("beat_ovf", 64'(k), 64'd2047);
                    else          check_eq("beat", 64'(cur), 64'(exp_beat(k)));
                    beat_total++;
                    last_hs = cyc;
                end
                stalled    = mon_if.valid && !mon_if.ready;
                stall_beat = cur;
                if (done) begin
                    done_total++;
                    check_eq("done_lat", 64'(cyc - last_hs), 64'd1);
                    check_eq("done_beats", 64'(beat_total - frame_base), 64'd2048);
                    check_eq("done_busy", 64'(busy), 64'd0);
                end
            end
        end
    end

    task automatic check_rst(input string tag);
        check_eq({tag, "_ctl"}, 64'({valid, busy, done, rd_en, rd_addr, ovr}), 64'd0);
        check_eq({tag, "_pix"}, 64'({pdata, px, py, sof, eol}), 64'd0);
    endtask

    task automatic start_frame();
        frame_base = beat_total;
        rd_base    = rd_total;
        frame_req  = 1'b1;
        @(posedge clk);
        #1;
        frame_req  = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit req_at_done);
        int t;
        t = 0;
        while (!done && t < 20000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("timeout", 64'(t < 20000), 64'd1);
        if (req_at_done && done) begin
            frame_req = 1'b1;
            @(posedge clk);
            #1;
            frame_req = 1'b0;
            exp_ovr++;
        end else begin
            @(posedge clk);
            #1;
        end
        check_eq("frame_reads", 64'(rd_total - rd_base), 64'd2048);
        check_eq("busy_end", 64'(busy), 64'd0);
        check_eq("overruns", 64'(ovr), 64'(exp_ovr));
        frame_no++;
        $display("frame %0d %s: beats=%0d reads=%0d overruns=%0d", frame_no, name,
                 beat_total - frame_base, rd_total - rd_base, ovr);
    endtask

    initial begin
        int d0, t;
        for (int i = 0; i < 2048; i++) vram[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_rst("rst");
        rst_n = 1'b1;
        ready_mode = 1;
        @(posedge clk);
        #1;

        // All-zero frame with start-up latency checks and a request on the done cycle.
        start_frame();
        check_eq("t0_busy", 64'(busy), 64'd1);
        check_eq("t0_rden", 64'(rd_en), 64'd1);
        check_eq("t0_valid", 64'(valid), 64'd0);
        @(posedge clk);
        #1;
        check_eq("t1_valid", 64'(valid), 64'd0);
        check_eq("t1_addr", 64'(rd_addr), 64'd1);
        @(posedge clk);
        #1;
        check_eq("t2_valid", 64'(valid), 64'd1);
        check_eq("t2_sof", 64'({px, py, sof}), 64'd1);
        wait_done("zero", 1'b1);

        // Corner pixels lit.
        vram[0] = 32'hFFFF_FFFF;
        vram[2047] = 32'hFFFF_FFFF;
        start_frame();
        wait_done("corners", 1'b0);

        // Checkerboard under random backpressure.
        for (int i = 0; i < 2048; i++)
            vram[i] = (((i % 64) ^ (i / 64)) & 1) != 0 ? 32'h0000_0100 : 32'h0;
        ready_mode = 2;
        start_frame();
        wait_done("checker_rand", 1'b0);
        ready_mode = 1;

        // Three requests while busy.
        d0 = done_total;
        start_frame();
        for (int p = 0; p < 3; p++) begin
            repeat (200) @(posedge clk);
            #1;
            frame_req = 1'b1;
            @(posedge clk);
            #1;
            frame_req = 1'b0;
        end
        exp_ovr += 3;
        wait_done("overrun3", 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check_eq("one_frame", 64'(done_total - d0), 64'd1);
        check_eq("idle_after", 64'(busy), 64'd0);

        // 300 dropped requests saturate the counter.
        start_frame();
        frame_req = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        frame_req = 1'b0;
        exp_ovr = (exp_ovr + 300 > 255) ? 255 : exp_ovr + 300;
        check_eq("ovr_sat", 64'(ovr), 64'(exp_ovr));
        wait_done("overrun300", 1'b0);

        // Reset mid-frame at beat 1000, then a clean restart.
        start_frame();
        t = 0;
        while ((beat_total - frame_base) < 1000 && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("reach_1000", 64'(t < 5000), 64'd1);
        rst_n = 1'b0;
        #1;
        check_rst("midrst");
        exp_ovr = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_frame();
        wait_done("after_reset", 1'b0);

        // Ready held low: two reads, then silence until ready rises.
        ready_mode = 0;
        start_frame();
        repeat (10) @(posedge clk);
        #1;
        check_eq("stall_reads", 64'(rd_total - rd_base), 64'd2);
        check_eq("stall_rden", 64'(rd_en), 64'd0);
        check_eq("stall_valid", 64'(valid), 64'd1);
        ready_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("resume_reads", 64'((rd_total - rd_base) > 2), 64'd1);
        wait_done("ready_low", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
